// File: rtl/freq_pkg.sv
// ---------------------------------------------------------------------------
// freq_pkg
// Types and helpers shared by the frequency-meter path (gerador_amostra and
// controlador).
//   sel_t         : decade selector codes (1=100 kHz ... 6=1 Hz)
//   estado_t      : generator FSM states
//   meio_periodo  : half-period length in clk cycles for a selector code,
//                   0 for an invalid code
// ---------------------------------------------------------------------------
package freq_pkg;

    typedef enum logic [3:0] {
        SEL_100KHZ = 4'd1,
        SEL_10KHZ  = 4'd2,
        SEL_1KHZ   = 4'd3,
        SEL_100HZ  = 4'd4,
        SEL_10HZ   = 4'd5,
        SEL_1HZ    = 4'd6
    } sel_t;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ALTO   = 2'd1,
        BAIXO  = 2'd2
    } estado_t;

    // HALF = clk_hz / (2 * f_sel). With a constant clk_hz every branch folds
    // to a constant, so this is just a small lookup in hardware.
    // A zero result doubles as the "invalid selector" flag.
    function automatic int unsigned meio_periodo(input logic [3:0] sel,
                                                 input int unsigned clk_hz);
        case (sel)
            SEL_100KHZ: return clk_hz / 32'd200_000;
            SEL_10KHZ:  return clk_hz / 32'd20_000;
            SEL_1KHZ:   return clk_hz / 32'd2_000;
            SEL_100HZ:  return clk_hz / 32'd200;
            SEL_10HZ:   return clk_hz / 32'd20;
            SEL_1HZ:    return clk_hz / 32'd2;
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/divisor_meio_periodo.sv
// ---------------------------------------------------------------------------
// divisor_meio_periodo
// Loadable half-period counter. 'carga' restarts the count at 0 and captures
// a new half-period length; while 'en' is high the counter runs 0..half-1
// and wraps, strobing 'fim_meio' during the terminal cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : count enable (generator is running)
//   carga     : restart the count and load 'half'
//   half      : half-period length in clk cycles (non-zero when loaded)
//   fim_meio  : high while the count sits at half-1 and en is set
// ---------------------------------------------------------------------------
module divisor_meio_periodo
    import freq_pkg::*;
#(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             carga,
    input  logic [CNT_W-1:0] half,
    output logic             fim_meio
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] half_q;

    assign fim_meio = en && (cnt_q == (half_q - CNT_W'(1)));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, and all of them (including the latched
    // length) are cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            half_q <= '0;
        end else if (carga) begin
            cnt_q  <= '0;
            half_q <= half;
        end else if (en) begin
            if (fim_meio) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gerador_amostra.sv
// ---------------------------------------------------------------------------
// gerador_amostra
// Programmable decade square-wave generator used as calibration source and
// self-check stimulus for the frequency meter. Continuous or burst mode;
// selector changes only take effect at period boundaries.
//   clk, rst      : clock, asynchronous active-high reset
//   seletor       : frequency select (1=100 kHz .. 6=1 Hz, others invalid)
//   habilita      : run level; dropping it stops after the current period
//   rajada        : burst length in periods, 0 = continuous, latched at start
//   amostra       : generated square wave, 50% duty, registered
//   ativo         : a period is in progress
//   fim           : one-cycle pulse when a burst completes
//   periodos      : completed periods since start, wraps
//   sel_invalido  : selector sampled at start/boundary was invalid
// ---------------------------------------------------------------------------
module gerador_amostra
    import freq_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          CNT_W  = 25,
    parameter int          PER_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       seletor,
    input  logic             habilita,
    input  logic [PER_W-1:0] rajada,
    output logic             amostra,
    output logic             ativo,
    output logic             fim,
    output logic [PER_W-1:0] periodos,
    output logic             sel_invalido
);

    estado_t          estado_q;
    logic             amostra_q;
    logic             fim_q;
    logic             sel_inv_q;
    logic [PER_W-1:0] periodos_q;
    logic [PER_W-1:0] rajada_q;

    logic [CNT_W-1:0] half_sel;
    logic             sel_ok;
    logic [PER_W-1:0] periodos_inc;
    logic             fim_rajada;
    logic             carga;
    logic             em_curso;
    logic             fim_meio;

    assign em_curso = (estado_q != OCIOSO);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        half_sel     = CNT_W'(meio_periodo(seletor, CLK_HZ));
        sel_ok       = (half_sel != '0);
        periodos_inc = periodos_q + PER_W'(1);
        fim_rajada   = (rajada_q != '0) && (periodos_inc == rajada_q);
        carga        = 1'b0;
        case (estado_q)
            OCIOSO:  carga = habilita && sel_ok;
            // Continuing into a new period re-latches the current selector.
            BAIXO:   carga = fim_meio && !fim_rajada && habilita && sel_ok;
            default: carga = 1'b0;
        endcase
    end

    divisor_meio_periodo #(
        .CNT_W (CNT_W)
    ) u_divisor (
        .clk      (clk),
        .rst      (rst),
        .en       (em_curso),
        .carga    (carga),
        .half     (half_sel),
        .fim_meio (fim_meio)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            amostra_q  <= 1'b0;
            fim_q      <= 1'b0;
            sel_inv_q  <= 1'b0;
            periodos_q <= '0;
            rajada_q   <= '0;
        end else begin
            fim_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (habilita) begin
                        if (sel_ok) begin
                            rajada_q   <= rajada;
                            periodos_q <= '0;
                            sel_inv_q  <= 1'b0;
                            amostra_q  <= 1'b1;
                            estado_q   <= ALTO;
                        end else begin
                            sel_inv_q <= 1'b1;
                        end
                    end
                end
                ALTO: begin
                    if (fim_meio) begin
                        amostra_q <= 1'b0;
                        estado_q  <= BAIXO;
                    end
                end
                BAIXO: begin
                    if (fim_meio) begin
                        periodos_q <= periodos_inc;
                        // Burst end has priority over a simultaneous stop.
                        if (fim_rajada) begin
                            fim_q    <= 1'b1;
                            estado_q <= OCIOSO;
                        end else if (!habilita) begin
                            estado_q <= OCIOSO;
                        end else if (!sel_ok) begin
                            sel_inv_q <= 1'b1;
                            estado_q  <= OCIOSO;
                        end else begin
                            amostra_q <= 1'b1;
                            estado_q  <= ALTO;
                        end
                    end
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign amostra      = amostra_q;
    assign ativo        = em_curso;
    assign fim          = fim_q;
    assign periodos     = periodos_q;
    assign sel_invalido = sel_inv_q;

endmodule

// File: tb/tb_gerador_amostra.sv
// ---------------------------------------------------------------------------
// tb_gerador_amostra
// Directed bench for gerador_amostra: a table of burst vectors plus
// hand-written sequences for switching, stopping, invalid selectors, async
// reset and a slow-clock instance. Inputs change and outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_gerador_amostra;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, 50 MHz
    logic        rst;
    logic [3:0]  seletor;
    logic        habilita;
    logic [15:0] rajada;
    logic        amostra, ativo, fim, sel_invalido;
    logic [15:0] periodos;

    // Slow instance, 1 MHz
    logic        s_rst;
    logic [3:0]  s_seletor;
    logic        s_habilita;
    logic [15:0] s_rajada;
    logic        s_amostra, s_ativo, s_fim, s_sel_invalido;
    logic [15:0] s_periodos;

    gerador_amostra #(
        .CLK_HZ (50_000_000), .CNT_W (25), .PER_W (16)
    ) dut (
        .clk (clk), .rst (rst), .seletor (seletor), .habilita (habilita),
        .rajada (rajada), .amostra (amostra), .ativo (ativo), .fim (fim),
        .periodos (periodos), .sel_invalido (sel_invalido)
    );

    gerador_amostra #(
        .CLK_HZ (1_000_000), .CNT_W (19), .PER_W (16)
    ) dut_lento (
        .clk (clk), .rst (s_rst), .seletor (s_seletor), .habilita (s_habilita),
        .rajada (s_rajada), .amostra (s_amostra), .ativo (s_ativo), .fim (s_fim),
        .periodos (s_periodos), .sel_invalido (s_sel_invalido)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts falling edges while amostra holds 'lvl' and a period is running.
    task automatic run_len(input logic lvl, input int lim, output int n);
        n = 0;
        while (amostra === lvl && ativo === 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] raj;
        int          half;
    } vec_t;

    vec_t tab [4];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int rises;
        int fims;
        logic prev;

        tab[0] = '{sel: 4'd1, raj: 16'd3, half: 250};
        tab[1] = '{sel: 4'd2, raj: 16'd1, half: 2500};
        tab[2] = '{sel: 4'd1, raj: 16'd1, half: 250};
        tab[3] = '{sel: 4'd1, raj: 16'd2, half: 250};

        rst = 1'b1; seletor = 4'd0; habilita = 1'b0; rajada = '0;
        s_rst = 1'b1; s_seletor = 4'd0; s_habilita = 1'b0; s_rajada = '0;
        step(3);
        check("reset amostra", amostra, 0);
        check("reset ativo", ativo, 0);
        check("reset fim", fim, 0);
        check("reset periodos", periodos, 0);
        check("reset sel_invalido", sel_invalido, 0);
        rst = 1'b0; s_rst = 1'b0;
        step(2);
        check("idle amostra", amostra, 0);

        // ---- Table-driven bursts ----
        for (int r = 0; r < 4; r++) begin
            seletor = tab[r].sel; rajada = tab[r].raj; habilita = 1'b1;
            step(1);
            check("burst start latency", amostra, 1);
            rajada = '0;  // must be ignored after start
            for (int k = 0; k < int'(tab[r].raj); k++) begin
                run_len(1'b1, 4 * tab[r].half + 10, n);
                check("burst high len", n, tab[r].half);
                run_len(1'b0, 4 * tab[r].half + 10, n);
                check("burst low len", n, tab[r].half);
                check("burst fim at end only", fim, (k == int'(tab[r].raj) - 1) ? 1 : 0);
            end
            habilita = 1'b0;
            step(1);
            check("burst fim one cycle", fim, 0);
            check("burst ativo after", ativo, 0);
            check("burst amostra after", amostra, 0);
            check("burst periodos", periodos, 32'(tab[r].raj));
        end

        // ---- Burst end and habilita drop at the same boundary ----
        seletor = 4'd1; rajada = 16'd1; habilita = 1'b1;
        step(1);
        habilita = 1'b0;
        run_len(1'b1, 1000, n);
        check("burst+stop high", n, 250);
        run_len(1'b0, 1000, n);
        check("burst+stop low", n, 250);
        check("burst+stop fim wins", fim, 1);
        step(1);
        check("burst+stop idle", ativo, 0);

        // ---- habilita held after burst restarts next cycle ----
        rajada = 16'd1; habilita = 1'b1;
        step(1);
        run_len(1'b1, 1000, n);
        run_len(1'b0, 1000, n);
        check("restart fim", fim, 1);
        check("restart periodos at fim", periodos, 1);
        step(1);
        check("restart amostra", amostra, 1);
        check("restart periodos cleared", periodos, 0);
        habilita = 1'b0;
        run_len(1'b1, 1000, n);
        run_len(1'b0, 1000, n);
        check("restart second fim", fim, 1);
        step(1);

        // ---- Continuous 10 kHz, then selector switch mid-ALTO ----
        seletor = 4'd2; rajada = '0; habilita = 1'b1;
        step(1);
        check("cont start", amostra, 1);
        run_len(1'b1, 10000, n);
        check("cont 10k high", n, 2500);
        run_len(1'b0, 10000, n);
        check("cont 10k low", n, 2500);
        step(100);
        check("switch mid high", amostra, 1);
        seletor = 4'd1;
        run_len(1'b1, 10000, n);
        check("switch rest of high", n, 2400);
        run_len(1'b0, 10000, n);
        check("switch old low", n, 2500);
        run_len(1'b1, 10000, n);
        check("switch new high", n, 250);
        run_len(1'b0, 10000, n);
        check("switch new low", n, 250);
        check("switch periodos", periodos, 3);

        // ---- 10 periods at 100 kHz ----
        prev = amostra; rises = 0; fims = 0;
        for (int i = 0; i < 5000; i++) begin
            step(1);
            if (amostra && !prev) rises++;
            if (fim) fims++;
            prev = amostra;
        end
        check("cont rising edges", rises, 10);
        check("cont no fim", fims, 0);
        check("cont periodos", periodos, 13);

        // ---- Stop: habilita drops 100 clk into a 10 kHz high phase ----
        seletor = 4'd2;
        run_len(1'b1, 10000, n);
        check("pre-stop high", n, 250);
        run_len(1'b0, 10000, n);
        check("pre-stop low", n, 250);
        step(100);
        habilita = 1'b0;
        run_len(1'b1, 10000, n);
        check("stop high", n, 2400);
        run_len(1'b0, 10000, n);
        check("stop low", n, 2500);
        check("stop no fim", fim, 0);
        check("stop ativo", ativo, 0);
        check("stop periodos", periodos, 15);
        step(5);
        check("stop stays low", amostra, 0);

        // ---- Invalid selector at a boundary ----
        seletor = 4'd1; habilita = 1'b1;
        step(1);
        seletor = 4'd9;
        run_len(1'b1, 1000, n);
        check("bnd-inv high", n, 250);
        run_len(1'b0, 1000, n);
        check("bnd-inv low", n, 250);
        check("bnd-inv flag", sel_invalido, 1);
        check("bnd-inv no fim", fim, 0);
        check("bnd-inv periodos", periodos, 1);
        habilita = 1'b0;
        step(2);

        // ---- Invalid selector in idle, then a valid one ----
        seletor = 4'd0; habilita = 1'b1;
        step(1);
        check("inv0 amostra", amostra, 0);
        check("inv0 flag", sel_invalido, 1);
        check("inv0 ativo", ativo, 0);
        seletor = 4'd7;
        step(2);
        check("inv7 amostra", amostra, 0);
        check("inv7 flag", sel_invalido, 1);
        check("inv7 ativo", ativo, 0);
        seletor = 4'd3;
        step(1);
        check("valid after inv latency", amostra, 1);
        check("valid clears flag", sel_invalido, 0);

        // ---- Async reset mid-ALTO ----
        step(50);
        check("pre-reset high", amostra, 1);
        #1 rst = 1'b1;
        #1;
        check("async rst amostra", amostra, 0);
        check("async rst periodos", periodos, 0);
        check("async rst ativo", ativo, 0);
        seletor = 4'd1;
        #1 rst = 1'b0;
        @(negedge clk);
        check("post-reset start", amostra, 1);
        run_len(1'b1, 1000, n);
        check("post-reset high", n, 250);
        habilita = 1'b0;
        run_len(1'b0, 1000, n);
        check("post-reset low", n, 250);
        check("post-reset periodos", periodos, 1);

        // ---- Slow instance: 1 MHz clock ----
        s_seletor = 4'd3; s_habilita = 1'b1;
        step(1);
        check("slow start", s_amostra, 1);
        s_habilita = 1'b0;
        n = 0;
        while (s_amostra === 1'b1 && n < 2000) begin step(1); n++; end
        check("slow 1k high", n, 500);
        n = 0;
        while (s_amostra === 1'b0 && s_ativo === 1'b1 && n < 2000) begin step(1); n++; end
        check("slow 1k low", n, 500);
        check("slow idle", s_ativo, 0);
        s_seletor = 4'd6; s_habilita = 1'b1;
        step(1);
        s_habilita = 1'b0;
        check("slow 1Hz start", s_amostra, 1);
        step(2000);
        check("slow 1Hz still high", s_amostra, 1);
        check("slow 1Hz ativo", s_ativo, 1);
        check("slow 1Hz no invalid", s_sel_invalido, 0);
        s_rst = 1'b1;
        step(1);
        check("slow reset", s_amostra, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
